// File: rtl/graphite_pkg.sv
// ---------------------------------------------------------------------------
// graphite_pkg: shared opcodes, FSM states and pixel packing. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package graphite_pkg;

  localparam int OP_POS  = 12;
  localparam int OP_SIZE = 4;

  localparam logic [OP_SIZE-1:0] OP_NOP       = 4'd0;
  localparam logic [OP_SIZE-1:0] OP_CLEAR     = 4'd1;
  localparam logic [OP_SIZE-1:0] OP_FILL_RECT = 4'd2;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_ARGS       = 3'd1,
    ST_RECT_SETUP = 3'd2,
    ST_CLEAR_RUN  = 3'd3,
    ST_RECT_RUN   = 3'd4
  } state_e;

  function automatic logic [15:0] pixel_word(input logic [11:0] colour);
    return {4'hF, colour};
  endfunction

endpackage

`default_nettype wire

// File: rtl/graphite_rect_walker.sv
// ---------------------------------------------------------------------------
// graphite_rect_walker: row-major pixel walker driving the VRAM sel/ack loop. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module graphite_rect_walker
  import graphite_pkg::*;
#(
  parameter int FB_WIDTH        = 128,
  parameter int VRAM_ADDR_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       reset_ni,
  input  logic                       start,
  input  logic [VRAM_ADDR_WIDTH-1:0] x_min,
  input  logic [VRAM_ADDR_WIDTH-1:0] x_max,
  input  logic [VRAM_ADDR_WIDTH-1:0] y_min,
  input  logic [VRAM_ADDR_WIDTH-1:0] y_max,
  input  logic [VRAM_ADDR_WIDTH-1:0] row_base_init,
  input  logic                       ack,
  output logic                       sel,
  output logic [VRAM_ADDR_WIDTH-1:0] addr,
  output logic                       done
);

  localparam int AW = VRAM_ADDR_WIDTH;
  localparam logic [AW-1:0] ROW_STEP = AW'(FB_WIDTH);

  logic [AW-1:0] x;
  logic [AW-1:0] y;
  logic [AW-1:0] row_base;
  logic [AW-1:0] x_lo;
  logic [AW-1:0] x_hi;
  logic [AW-1:0] y_hi;
  logic          step;
  logic          last_col;
  logic          last_row;

  assign step     = sel && ack;
  assign last_col = (x == x_hi);
  assign last_row = (y == y_hi);
  assign done     = step && last_col && last_row;
  // Addressing is purely incremental: row_base advances by one row per wrap.
  assign addr     = row_base + x;

  always_ff @(posedge clk) begin
    if (!reset_ni) begin
      sel      <= 1'b0;
      x        <= '0;
      y        <= '0;
      row_base <= '0;
      x_lo     <= '0;
      x_hi     <= '0;
      y_hi     <= '0;
    end else if (start) begin
      sel      <= 1'b1;
      x        <= x_min;
      y        <= y_min;
      row_base <= row_base_init;
      x_lo     <= x_min;
      x_hi     <= x_max;
      y_hi     <= y_max;
    end else if (step) begin
      if (!last_col) begin
        x <= x + 1'b1;
      end else if (!last_row) begin
        x        <= x_lo;
        y        <= y + 1'b1;
        row_base <= row_base + ROW_STEP;
      end else begin
        sel <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/graphite_cmd_engine.sv
// ---------------------------------------------------------------------------
// graphite_cmd_engine: AXI-stream command processor for NOP/CLEAR/FILL_RECT. Rev 1.0
// Optional macro GRAPHITE_RECT_CLIP_EN clamps rectangles instead of dropping them.
// ---------------------------------------------------------------------------
`default_nettype none

module graphite_cmd_engine
  import graphite_pkg::*;
#(
  parameter int FB_WIDTH         = 128,
  parameter int FB_HEIGHT        = 128,
  parameter int CMD_STREAM_WIDTH = 16,
  parameter int VRAM_ADDR_WIDTH  = 16
) (
  input  logic                        clk,
  input  logic                        reset_ni,
  input  logic                        cmd_axis_tvalid_i,
  output logic                        cmd_axis_tready_o,
  input  logic [CMD_STREAM_WIDTH-1:0] cmd_axis_tdata_i,
  input  logic                        vram_ack_i,
  output logic                        vram_sel_o,
  output logic                        vram_wr_o,
  output logic [3:0]                  vram_mask_o,
  output logic [VRAM_ADDR_WIDTH-1:0]  vram_addr_o,
  output logic [15:0]                 vram_data_out_o,
  output logic                        busy_o
);

  localparam int AW = VRAM_ADDR_WIDTH;
  localparam logic [AW-1:0] W_LAST   = AW'(FB_WIDTH - 1);
  localparam logic [AW-1:0] H_LAST   = AW'(FB_HEIGHT - 1);
  localparam logic [AW-1:0] ROW_STEP = AW'(FB_WIDTH);

  state_e              state;
  state_e              state_n;
  logic [11:0]         colour;
  logic [AW-1:0]       args [4];
  logic [1:0]          arg_cnt;
  logic                launch;
  logic                tready;
  logic                xfer;
  logic [OP_SIZE-1:0]  opcode;
  logic [AW-1:0]       arg_word;

  logic [AW-1:0]       x_lo;
  logic [AW-1:0]       x_hi;
  logic [AW-1:0]       y_lo;
  logic [AW-1:0]       y_hi;
  logic [AW-1:0]       rect_row_base;
  logic                rect_ok;

  logic                walk_start;
  logic [AW-1:0]       walk_x_min;
  logic [AW-1:0]       walk_x_max;
  logic [AW-1:0]       walk_y_min;
  logic [AW-1:0]       walk_y_max;
  logic [AW-1:0]       walk_row_base;
  logic                walk_sel;
  logic                walk_done;
  logic [AW-1:0]       walk_addr;

  assign xfer   = cmd_axis_tvalid_i && tready;
  assign opcode = cmd_axis_tdata_i[OP_POS +: OP_SIZE];

  generate
    if (VRAM_ADDR_WIDTH <= CMD_STREAM_WIDTH) begin : g_arg_slice
      assign arg_word = cmd_axis_tdata_i[VRAM_ADDR_WIDTH-1:0];
    end else begin : g_arg_extend
      assign arg_word = {{(VRAM_ADDR_WIDTH-CMD_STREAM_WIDTH){1'b0}}, cmd_axis_tdata_i};
    end
  endgenerate

  // Normalise, then either clamp or validate; the only multiply lives here.
  always_comb begin
    x_lo    = (args[0] <= args[2]) ? args[0] : args[2];
    x_hi    = (args[0] <= args[2]) ? args[2] : args[0];
    y_lo    = (args[1] <= args[3]) ? args[1] : args[3];
    y_hi    = (args[1] <= args[3]) ? args[3] : args[1];
    rect_ok = 1'b1;
`ifdef GRAPHITE_RECT_CLIP_EN
    if (x_lo > W_LAST) x_lo = W_LAST;
    if (x_hi > W_LAST) x_hi = W_LAST;
    if (y_lo > H_LAST) y_lo = H_LAST;
    if (y_hi > H_LAST) y_hi = H_LAST;
`else
    rect_ok = (x_hi <= W_LAST) && (y_hi <= H_LAST);
`endif
    rect_row_base = y_lo * ROW_STEP;
  end

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE: begin
        if (xfer) begin
          case (opcode)
            OP_CLEAR:     state_n = ST_CLEAR_RUN;
            OP_FILL_RECT: state_n = ST_ARGS;
            default:      state_n = ST_IDLE;
          endcase
        end
      end
      ST_ARGS: begin
        if (xfer && (arg_cnt == 2'd3)) state_n = ST_RECT_SETUP;
      end
      ST_RECT_SETUP: state_n = rect_ok ? ST_RECT_RUN : ST_IDLE;
      ST_CLEAR_RUN, ST_RECT_RUN: begin
        if (walk_done) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_ni) state <= ST_IDLE;
    else           state <= state_n;
  end

  // CLEAR spends its first CLEAR_RUN cycle launching the walker over the full frame.
  always_ff @(posedge clk) begin
    if (!reset_ni) begin
      colour  <= '0;
      arg_cnt <= '0;
      launch  <= 1'b0;
      tready  <= 1'b0;
      for (int i = 0; i < 4; i++) args[i] <= '0;
    end else begin
      launch <= (state == ST_IDLE) && xfer && (opcode == OP_CLEAR);
      tready <= (state_n == ST_IDLE) || (state_n == ST_ARGS);
      if ((state == ST_IDLE) && xfer &&
          ((opcode == OP_CLEAR) || (opcode == OP_FILL_RECT))) begin
        colour  <= cmd_axis_tdata_i[11:0];
        arg_cnt <= '0;
      end
      if ((state == ST_ARGS) && xfer) begin
        args[arg_cnt] <= arg_word;
        arg_cnt       <= arg_cnt + 2'd1;
      end
    end
  end

  always_comb begin
    walk_start    = launch || ((state == ST_RECT_SETUP) && rect_ok);
    walk_x_min    = x_lo;
    walk_x_max    = x_hi;
    walk_y_min    = y_lo;
    walk_y_max    = y_hi;
    walk_row_base = rect_row_base;
    if (state == ST_CLEAR_RUN) begin
      walk_x_min    = '0;
      walk_x_max    = W_LAST;
      walk_y_min    = '0;
      walk_y_max    = H_LAST;
      walk_row_base = '0;
    end
  end

  graphite_rect_walker #(
    .FB_WIDTH        (FB_WIDTH),
    .VRAM_ADDR_WIDTH (VRAM_ADDR_WIDTH)
  ) u_walker (
    .clk           (clk),
    .reset_ni      (reset_ni),
    .start         (walk_start),
    .x_min         (walk_x_min),
    .x_max         (walk_x_max),
    .y_min         (walk_y_min),
    .y_max         (walk_y_max),
    .row_base_init (walk_row_base),
    .ack           (vram_ack_i),
    .sel           (walk_sel),
    .addr          (walk_addr),
    .done          (walk_done)
  );

  assign cmd_axis_tready_o = tready;
  assign vram_sel_o        = walk_sel;
  assign vram_wr_o         = walk_sel;
  assign vram_mask_o       = walk_sel ? 4'hF : 4'h0;
  assign vram_addr_o       = walk_addr;
  assign vram_data_out_o   = walk_sel ? pixel_word(colour) : 16'h0000;
  assign busy_o            = (state != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_graphite_cmd_engine.sv
// ---------------------------------------------------------------------------
// tb_graphite_cmd_engine: randomized self-checking bench on an 8x8 framebuffer. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_graphite_cmd_engine;

  localparam int W  = 8;
  localparam int H  = 8;
  localparam int CW = 16;
  localparam int AW = 16;

  logic          clk = 1'b0;
  logic          reset_ni = 1'b0;
  logic          tvalid = 1'b0;
  logic [CW-1:0] tdata = '0;
  logic          ack = 1'b0;
  logic          tready;
  logic          sel;
  logic          wr;
  logic [3:0]    mask;
  logic [AW-1:0] addr;
  logic [15:0]   data;
  logic          busy;

  always #5 clk = ~clk;

  graphite_cmd_engine #(
    .FB_WIDTH         (W),
    .FB_HEIGHT        (H),
    .CMD_STREAM_WIDTH (CW),
    .VRAM_ADDR_WIDTH  (AW)
  ) dut (
    .clk               (clk),
    .reset_ni          (reset_ni),
    .cmd_axis_tvalid_i (tvalid),
    .cmd_axis_tready_o (tready),
    .cmd_axis_tdata_i  (tdata),
    .vram_ack_i        (ack),
    .vram_sel_o        (sel),
    .vram_wr_o         (wr),
    .vram_mask_o       (mask),
    .vram_addr_o       (addr),
    .vram_data_out_o   (data),
    .busy_o            (busy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // ack_mode: 0 = always high, 1 = one cycle in three, 2 = random
  int          ack_mode  = 0;
  int          ack_phase = 0;
  int unsigned wr_addr[$];
  logic [15:0] wr_data[$];
  int          sel_cycles = 0;
  int          stab_err   = 0;
  int          proto_err  = 0;
  logic        prev_pending = 1'b0;
  logic [AW-1:0] prev_addr = '0;
  logic [15:0]   prev_data = '0;
  int unsigned exp_q[$];

  // VRAM side: choose the ack the next edge will see and log accepted writes.
  always @(negedge clk) begin
    logic a;
    if (prev_pending && !(sel && addr == prev_addr && data == prev_data)) stab_err++;
    case (ack_mode)
      0:       a = 1'b1;
      1:       a = (ack_phase == 2);
      default: a = 1'($urandom_range(0, 1));
    endcase
    ack_phase = (ack_phase == 2) ? 0 : ack_phase + 1;
    ack = a;
    if (sel) begin
      sel_cycles++;
      if (wr !== 1'b1 || mask !== 4'hF) proto_err++;
    end
    if (sel && a) begin
      wr_addr.push_back(int'(addr));
      wr_data.push_back(data);
    end
    prev_pending = sel && !a;
    prev_addr    = addr;
    prev_data    = data;
  end

  function automatic void clear_log();
    wr_addr.delete();
    wr_data.delete();
    sel_cycles = 0;
    stab_err   = 0;
    proto_err  = 0;
  endfunction

  // Reference: the set of pixels a rectangle command must write, row-major.
  function automatic void model_rect(int x0, int y0, int x1, int y1);
    int xl, xh, yl, yh;
    exp_q.delete();
    xl = (x0 < x1) ? x0 : x1;
    xh = (x0 < x1) ? x1 : x0;
    yl = (y0 < y1) ? y0 : y1;
    yh = (y0 < y1) ? y1 : y0;
`ifdef GRAPHITE_RECT_CLIP_EN
    if (xl > W-1) xl = W-1;
    if (xh > W-1) xh = W-1;
    if (yl > H-1) yl = H-1;
    if (yh > H-1) yh = H-1;
`else
    if (xh >= W || yh >= H) return;
`endif
    for (int y = yl; y <= yh; y++)
      for (int x = xl; x <= xh; x++)
        exp_q.push_back(y * W + x);
  endfunction

  // Called at a negedge; returns at the negedge following the transfer edge.
  task automatic send(input logic [CW-1:0] w);
    int n;
    n = 0;
    tvalid = 1'b1;
    tdata  = w;
    while (!tready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout word=%h tready stayed 0 for %0d cycles, expected 1", w, n);
    end
    @(negedge clk);
    tvalid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy || sel) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 5000) begin
      n_checks++;
      n_fail++;
      $display("FAIL idle_timeout busy=%b sel=%b after %0d cycles, expected 0", busy, sel, n);
    end
  endtask

  task automatic do_rect(input logic [11:0] colour, input int x0, input int y0,
                         input int x1, input int y1);
    send({4'h2, colour});
    send(CW'(x0));
    send(CW'(y0));
    send(CW'(x1));
    send(CW'(y1));
    wait_idle();
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset_ni = 1'b0;
    tvalid   = 1'b1;
    tdata    = 16'h1ABC;
    repeat (3) begin
      @(negedge clk);
      n_checks++;
      if (tready !== 1'b0 || sel !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_hold tready=%b sel=%b, expected 0 0", tready, sel);
      end
    end
    n_checks++;
    if (busy !== 1'b0 || wr !== 1'b0 || mask !== 4'h0 || addr !== '0 || data !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_values busy=%b wr=%b mask=%h addr=%h data=%h, expected all 0",
               busy, wr, mask, addr, data);
    end
    reset_ni = 1'b1;
    tvalid   = 1'b0;
    @(negedge clk);
    n_checks++;
    if (tready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release tready=%b busy=%b, expected 1 0", tready, busy);
    end
  endtask

  task automatic test_clear();
    int n;
    ack_mode = 0;
    clear_log();
    send(16'h1ABC);
    n = 0;
    while (busy && n < 1000) begin
      n++;
      @(negedge clk);
    end
    n_checks++;
    if (n !== W*H + 1) begin
      n_fail++;
      $display("FAIL clear_busy_cycles actual=%0d expected=%0d", n, W*H + 1);
    end
    n_checks++;
    if (tready !== 1'b1) begin
      n_fail++;
      $display("FAIL clear_tready_after actual=%b expected=1", tready);
    end
    n_checks++;
    if (wr_addr.size() !== W*H || proto_err !== 0) begin
      n_fail++;
      $display("FAIL clear_count writes=%0d proto_err=%0d, expected %0d 0",
               wr_addr.size(), proto_err, W*H);
    end
    for (int i = 0; i < wr_addr.size() && i < W*H; i++) begin
      n_checks++;
      if (wr_addr[i] !== i || wr_data[i] !== 16'hFABC) begin
        n_fail++;
        $display("FAIL clear_write[%0d] addr=%0d data=%h, expected %0d FABC",
                 i, wr_addr[i], wr_data[i], i);
      end
    end
  endtask

  task automatic test_ack_toggle();
    ack_mode = 1;
    clear_log();
    send(16'h1321);
    wait_idle();
    n_checks++;
    if (stab_err !== 0 || proto_err !== 0) begin
      n_fail++;
      $display("FAIL ack_toggle_stable stab_err=%0d proto_err=%0d, expected 0 0",
               stab_err, proto_err);
    end
    n_checks++;
    if (wr_addr.size() !== W*H) begin
      n_fail++;
      $display("FAIL ack_toggle_count actual=%0d expected=%0d", wr_addr.size(), W*H);
    end
    for (int i = 0; i < wr_addr.size() && i < W*H; i++) begin
      n_checks++;
      if (wr_addr[i] !== i || wr_data[i] !== 16'hF321) begin
        n_fail++;
        $display("FAIL ack_toggle_write[%0d] addr=%0d data=%h, expected %0d F321",
                 i, wr_addr[i], wr_data[i], i);
      end
    end
    ack_mode = 0;
  endtask

  task automatic test_fill_rect();
    int tbl [6][4] = '{'{5,1,3,2}, '{4,4,4,4}, '{2,0,2,7}, '{0,0,7,7}, '{7,3,0,3}, '{6,6,1,5}};
    logic [11:0] colour;
    for (int t = 0; t < 6; t++) begin
      ack_mode = (t < 2) ? 0 : 2;
      colour = (t == 0) ? 12'h123 : 12'($urandom);
      model_rect(tbl[t][0], tbl[t][1], tbl[t][2], tbl[t][3]);
      clear_log();
      do_rect(colour, tbl[t][0], tbl[t][1], tbl[t][2], tbl[t][3]);
      n_checks++;
      if (wr_addr.size() !== exp_q.size() || stab_err !== 0 || proto_err !== 0) begin
        n_fail++;
        $display("FAIL rect%0d_count writes=%0d stab=%0d proto=%0d, expected %0d 0 0",
                 t, wr_addr.size(), stab_err, proto_err, exp_q.size());
      end
      for (int i = 0; i < wr_addr.size() && i < exp_q.size(); i++) begin
        n_checks++;
        if (wr_addr[i] !== exp_q[i] || wr_data[i] !== {4'hF, colour}) begin
          n_fail++;
          $display("FAIL rect%0d_write[%0d] addr=%0d data=%h, expected %0d %h",
                   t, i, wr_addr[i], wr_data[i], exp_q[i], {4'hF, colour});
        end
      end
    end
    ack_mode = 0;
  endtask

  task automatic test_clip();
    int tbl [3][4] = '{'{6,2,9,3}, '{9,1,12,2}, '{3,9,3,9}};
    for (int t = 0; t < 3; t++) begin
      ack_mode = 0;
      model_rect(tbl[t][0], tbl[t][1], tbl[t][2], tbl[t][3]);
      clear_log();
      do_rect(12'h456, tbl[t][0], tbl[t][1], tbl[t][2], tbl[t][3]);
      n_checks++;
      if (sel_cycles !== exp_q.size() || wr_addr.size() !== exp_q.size()) begin
        n_fail++;
        $display("FAIL clip%0d_count sel_cycles=%0d writes=%0d, expected %0d %0d",
                 t, sel_cycles, wr_addr.size(), exp_q.size(), exp_q.size());
      end
      for (int i = 0; i < wr_addr.size() && i < exp_q.size(); i++) begin
        n_checks++;
        if (wr_addr[i] !== exp_q[i] || wr_data[i] !== 16'hF456) begin
          n_fail++;
          $display("FAIL clip%0d_write[%0d] addr=%0d data=%h, expected %0d F456",
                   t, i, wr_addr[i], wr_data[i], exp_q[i]);
        end
      end
      n_checks++;
      if (tready !== 1'b1 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL clip%0d_idle tready=%b busy=%b, expected 1 0", t, tready, busy);
      end
    end
  endtask

  task automatic test_back_to_back();
    int x0, y0, x1, y1;
    logic [11:0] colour;
    for (int t = 0; t < 20; t++) begin
      ack_mode = 2;
      x0 = $urandom_range(0, 9);
      y0 = $urandom_range(0, 9);
      x1 = $urandom_range(0, 9);
      y1 = $urandom_range(0, 9);
      colour = 12'($urandom);
      model_rect(x0, y0, x1, y1);
      clear_log();
      if (t % 3 == 0) send(16'h0000);
      do_rect(colour, x0, y0, x1, y1);
      n_checks++;
      if (wr_addr.size() !== exp_q.size() || stab_err !== 0) begin
        n_fail++;
        $display("FAIL b2b%0d_count (%0d,%0d,%0d,%0d) writes=%0d stab=%0d, expected %0d 0",
                 t, x0, y0, x1, y1, wr_addr.size(), stab_err, exp_q.size());
      end
      for (int i = 0; i < wr_addr.size() && i < exp_q.size(); i++) begin
        n_checks++;
        if (wr_addr[i] !== exp_q[i] || wr_data[i] !== {4'hF, colour}) begin
          n_fail++;
          $display("FAIL b2b%0d_write[%0d] addr=%0d data=%h, expected %0d %h",
                   t, i, wr_addr[i], wr_data[i], exp_q[i], {4'hF, colour});
        end
      end
    end
    ack_mode = 0;
  endtask

  task automatic test_reset_mid();
    int n;
    ack_mode = 0;
    clear_log();
    send(16'h1555);
    n = 0;
    while (!(sel && addr == 5) && n < 200) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (n >= 200) begin
      n_fail++;
      $display("FAIL reset_mid_reach addr=%0d sel=%b, expected sel=1 at addr 5", addr, sel);
    end
    reset_ni = 1'b0;
    @(negedge clk);
    n_checks++;
    if (sel !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_drop sel=%b busy=%b, expected 0 0", sel, busy);
    end
    reset_ni = 1'b1;
    @(negedge clk);
    clear_log();
    send(16'h7000);
    n_checks++;
    if (busy !== 1'b0 || tready !== 1'b1) begin
      n_fail++;
      $display("FAIL bad_opcode_drop busy=%b tready=%b, expected 0 1", busy, tready);
    end
    send(16'h0000);
    repeat (4) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || sel_cycles !== 0 || wr_addr.size() !== 0) begin
      n_fail++;
      $display("FAIL nop_after_reset busy=%b sel_cycles=%0d writes=%0d, expected 0 0 0",
               busy, sel_cycles, wr_addr.size());
    end
  endtask

  initial begin
    test_reset();
    test_clear();
    test_ack_toggle();
    test_fill_rect();
    test_clip();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not complete, expected completion before 2000000");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
